fifo_flex: RTL and testbench

FIFO_FLEX -- requirements
Module: fifo_flex

---
 rtl/fifo_flex.sv | 130 +++++++++++++
 tb/tb_fifo_flex.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_flex.sv
// fifo_flex: synchronous first-word fall-through FIFO with arbitrary
// (non power-of-two) depth, registered occupancy counter, active-low
// status flags derived from that counter, and sticky overflow/underflow
// error bits. Storage is a circular buffer; only control state is reset.
module fifo_flex #(
    parameter int DATA_WIDTH    = 8,
    parameter int FIFO_DEPTH    = 5,
    parameter int COUNTER_WIDTH = $clog2(FIFO_DEPTH + 1),
    parameter int AF_LEVEL      = FIFO_DEPTH - 1,
    parameter int AE_LEVEL      = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_WIDTH-1:0]    din,
    input  logic                     enq,
    input  logic                     deq,
    input  logic                     clr,
    output logic [DATA_WIDTH-1:0]    dout,
    output logic                     full_n,
    output logic                     empty_n,
    output logic                     almost_full_n,
    output logic                     almost_empty_n,
    output logic [COUNTER_WIDTH-1:0] count,
    output logic                     overflow,
    output logic                     underflow
);

    // Pointer width covers indices 0..FIFO_DEPTH-1 (FIFO_DEPTH >= 2).
    localparam int PTR_WIDTH = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [PTR_WIDTH-1:0]     LP_PTR_LAST = PTR_WIDTH'(FIFO_DEPTH - 1);
    localparam logic [PTR_WIDTH-1:0]     LP_PTR_ONE  = PTR_WIDTH'(1);
    localparam logic [COUNTER_WIDTH-1:0] LP_CNT_FULL = COUNTER_WIDTH'(FIFO_DEPTH);
    localparam logic [COUNTER_WIDTH-1:0] LP_CNT_ONE  = COUNTER_WIDTH'(1);
    localparam logic [COUNTER_WIDTH-1:0] LP_AF_LEVEL = COUNTER_WIDTH'(AF_LEVEL);
    localparam logic [COUNTER_WIDTH-1:0] LP_AE_LEVEL = COUNTER_WIDTH'(AE_LEVEL);

    // Storage and control state
    logic [DATA_WIDTH-1:0]    r_mem [FIFO_DEPTH];
    logic [PTR_WIDTH-1:0]     r_wr_ptr;
    logic [PTR_WIDTH-1:0]     r_rd_ptr;
    logic [COUNTER_WIDTH-1:0] r_count;
    logic                     r_overflow;
    logic                     r_underflow;

    // Combinational helpers
    logic                     w_full;
    logic                     w_empty;
    logic                     w_do_wr;
    logic                     w_do_rd;
    logic                     w_ovf_evt;
    logic                     w_unf_evt;
    logic [PTR_WIDTH-1:0]     w_wr_ptr_nxt;
    logic [PTR_WIDTH-1:0]     w_rd_ptr_nxt;

    // Status decode from the registered count only.
    always_comb begin
        w_full  = (r_count == LP_CNT_FULL);
        w_empty = (r_count == '0);
    end

    // Accept/reject decisions; a pop in the same cycle frees the slot a full write needs.
    always_comb begin
        w_do_rd   = deq && !w_empty && !clr;
        w_do_wr   = enq && (!w_full || deq) && !clr;
        w_ovf_evt = enq && w_full && !deq;
        w_unf_evt = deq && w_empty;
    end

    // Circular pointer advance with explicit wrap at FIFO_DEPTH-1.
    always_comb begin
        w_wr_ptr_nxt = (r_wr_ptr == LP_PTR_LAST) ? '0 : r_wr_ptr + LP_PTR_ONE;
        w_rd_ptr_nxt = (r_rd_ptr == LP_PTR_LAST) ? '0 : r_rd_ptr + LP_PTR_ONE;
    end

    // Storage write; array contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers, occupancy and sticky errors; clr outranks enq/deq.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (clr) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= w_wr_ptr_nxt;
            end
            if (w_do_rd) begin
                r_rd_ptr <= w_rd_ptr_nxt;
            end
            case ({w_do_wr, w_do_rd})
                2'b10:   r_count <= r_count + LP_CNT_ONE;
                2'b01:   r_count <= r_count - LP_CNT_ONE;
                default: r_count <= r_count;
            endcase
            if (w_ovf_evt) begin
                r_overflow <= 1'b1;
            end
            if (w_unf_evt) begin
                r_underflow <= 1'b1;
            end
        end
    end

    // Output drive: fall-through head word, zero while empty.
    always_comb begin
        dout           = w_empty ? '0 : r_mem[r_rd_ptr];
        full_n         = !w_full;
        empty_n        = !w_empty;
        almost_full_n  = !(r_count >= LP_AF_LEVEL);
        almost_empty_n = !(r_count <= LP_AE_LEVEL);
        count          = r_count;
        overflow       = r_overflow;
        underflow      = r_underflow;
    end

endmodule

// File: tb/tb_fifo_flex.sv
// Directed self-checking bench for fifo_flex (8-bit, depth 5, AF=4, AE=1).
module tb_fifo_flex;

    logic       clk;
    logic       rst;
    logic [7:0] din;
    logic       enq;
    logic       deq;
    logic       clr;
    logic [7:0] dout;
    logic       full_n;
    logic       empty_n;
    logic       almost_full_n;
    logic       almost_empty_n;
    logic [2:0] count;
    logic       overflow;
    logic       underflow;

    int unsigned n_cmp;
    int unsigned n_err;

    fifo_flex #(
        .DATA_WIDTH (8),
        .FIFO_DEPTH (5),
        .AF_LEVEL   (4),
        .AE_LEVEL   (1)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .din            (din),
        .enq            (enq),
        .deq            (deq),
        .clr            (clr),
        .dout           (dout),
        .full_n         (full_n),
        .empty_n        (empty_n),
        .almost_full_n  (almost_full_n),
        .almost_empty_n (almost_empty_n),
        .count          (count),
        .overflow       (overflow),
        .underflow      (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock edge, then settle 1ns past it before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] v);
        enq = 1'b1; deq = 1'b0; din = v;
        tick();
        enq = 1'b0;
    endtask

    task automatic pop_expect(input string tag, input logic [7:0] v);
        check_val(tag, {24'd0, dout}, {24'd0, v});
        enq = 1'b0; deq = 1'b1;
        tick();
        deq = 1'b0;
    endtask

    logic [7:0] fill_v [5];
    logic [7:0] wrap_v [5];
    logic [7:0] ff_v   [5];

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1; din = '0; enq = 1'b0; deq = 1'b0; clr = 1'b0;
        fill_v = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        wrap_v = '{8'h44, 8'h55, 8'hA1, 8'hA2, 8'hA3};
        ff_v   = '{8'hB5, 8'hC1, 8'hC2, 8'hC3, 8'hC4};
        tick();
        tick();
        rst = 1'b0;

        // Stale data, then asynchronous reset mid-cycle
        push(8'h77);
        push(8'h88);
        check_val("stale_count", {29'd0, count}, 32'd2);
        #2 rst = 1'b1;
        #1;
        check_val("rst_count",   {29'd0, count},          32'd0);
        check_val("rst_empty_n", {31'd0, empty_n},        32'd0);
        check_val("rst_full_n",  {31'd0, full_n},         32'd1);
        check_val("rst_ae_n",    {31'd0, almost_empty_n}, 32'd0);
        check_val("rst_af_n",    {31'd0, almost_full_n},  32'd1);
        check_val("rst_dout",    {24'd0, dout},           32'd0);
        check_val("rst_ovf",     {31'd0, overflow},       32'd0);
        check_val("rst_unf",     {31'd0, underflow},      32'd0);
        rst = 1'b0;

        // Fill 0x11..0x55 and watch threshold flags
        for (int i = 0; i < 5; i++) begin
            push(fill_v[i]);
            check_val("fill_count", {29'd0, count},          32'(i + 1));
            check_val("fill_dout",  {24'd0, dout},           32'h11);
            check_val("fill_ae_n",  {31'd0, almost_empty_n}, (i + 1 >= 2) ? 32'd1 : 32'd0);
            check_val("fill_af_n",  {31'd0, almost_full_n},  (i + 1 >= 4) ? 32'd0 : 32'd1);
            check_val("fill_full_n",{31'd0, full_n},         (i + 1 == 5) ? 32'd0 : 32'd1);
        end

        // Write when full without pop
        push(8'h66);
        check_val("ovf_count", {29'd0, count},    32'd5);
        check_val("ovf_flag",  {31'd0, overflow}, 32'd1);
        for (int i = 0; i < 5; i++) pop_expect("drain_dout", fill_v[i]);
        check_val("drain_count",   {29'd0, count},   32'd0);
        check_val("drain_empty_n", {31'd0, empty_n}, 32'd0);
        check_val("drain_dout0",   {24'd0, dout},    32'd0);
        check_val("drain_ovf",     {31'd0, overflow},32'd1);

        // Wrap-around ordering
        for (int i = 0; i < 5; i++) push(fill_v[i]);
        for (int i = 0; i < 3; i++) pop_expect("wrap_pre", fill_v[i]);
        push(8'hA1);
        push(8'hA2);
        push(8'hA3);
        check_val("wrap_count", {29'd0, count}, 32'd5);
        for (int i = 0; i < 5; i++) pop_expect("wrap_dout", wrap_v[i]);

        // Flush sticky error before full-throughput test
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check_val("clr1_ovf", {31'd0, overflow}, 32'd0);

        // Simultaneous enq+deq while full
        for (int i = 0; i < 5; i++) push(8'hB1 + 8'(i));
        for (int i = 0; i < 4; i++) begin
            check_val("ff_head", {24'd0, dout}, 32'(8'hB1 + 8'(i)));
            enq = 1'b1; deq = 1'b1; din = 8'hC1 + 8'(i);
            tick();
            enq = 1'b0; deq = 1'b0;
            check_val("ff_count", {29'd0, count},    32'd5);
            check_val("ff_ovf",   {31'd0, overflow}, 32'd0);
        end
        for (int i = 0; i < 5; i++) pop_expect("ff_drain", ff_v[i]);

        // Pop on empty raises underflow, count unchanged
        deq = 1'b1;
        tick();
        deq = 1'b0;
        check_val("unf_flag",  {31'd0, underflow}, 32'd1);
        check_val("unf_count", {29'd0, count},     32'd0);

        // clr with enq at count 3: everything flushed, enq dropped
        push(8'hD1);
        push(8'hD2);
        push(8'hD3);
        check_val("pre_clr_count", {29'd0, count}, 32'd3);
        clr = 1'b1; enq = 1'b1; din = 8'hEE;
        tick();
        clr = 1'b0; enq = 1'b0;
        check_val("clr_count",   {29'd0, count},     32'd0);
        check_val("clr_empty_n", {31'd0, empty_n},   32'd0);
        check_val("clr_ovf",     {31'd0, overflow},  32'd0);
        check_val("clr_unf",     {31'd0, underflow}, 32'd0);
        check_val("clr_dout",    {24'd0, dout},      32'd0);

        // enq+deq on empty: write only, underflow set
        enq = 1'b1; deq = 1'b1; din = 8'h5A;
        tick();
        enq = 1'b0; deq = 1'b0;
        check_val("ed_count", {29'd0, count},     32'd1);
        check_val("ed_unf",   {31'd0, underflow}, 32'd1);
        check_val("ed_dout",  {24'd0, dout},      32'h5A);
        pop_expect("ed_pop", 8'h5A);
        check_val("ed_final_count", {29'd0, count}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
